// File: rtl/subtractor_mp_if.sv
// Operand/result handshake bundle for subtractor_mp.
// Optional feature macro: SUBTRACTOR_MP_OVF_EN adds the signed-overflow flag.
interface subtractor_mp_if #(
    parameter int unsigned OPERAND_WIDTH = 256
);
    logic                     op_valid;
    logic                     op_ready;
    logic [OPERAND_WIDTH-1:0] a;
    logic [OPERAND_WIDTH-1:0] b;
    logic                     op_borrow;
    logic                     res_valid;
    logic                     res_ready;
    logic [OPERAND_WIDTH-1:0] diff;
    logic                     res_borrow;
`ifdef SUBTRACTOR_MP_OVF_EN
    logic                     ovf;

    modport master (
        output op_valid, a, b, op_borrow, res_ready,
        input  op_ready, res_valid, diff, res_borrow, ovf
    );
    modport slave (
        input  op_valid, a, b, op_borrow, res_ready,
        output op_ready, res_valid, diff, res_borrow, ovf
    );
`else
    modport master (
        output op_valid, a, b, op_borrow, res_ready,
        input  op_ready, res_valid, diff, res_borrow
    );
    modport slave (
        input  op_valid, a, b, op_borrow, res_ready,
        output op_ready, res_valid, diff, res_borrow
    );
`endif
endinterface

// File: rtl/subtractor_mp.sv
// Multi-cycle multi-precision subtractor: diff = a - b - borrow, one chunk per
// cycle LSB-first with a registered inter-chunk borrow.
// Optional feature macro: SUBTRACTOR_MP_OVF_EN (signed-overflow output).
module subtractor_mp #(
    parameter int unsigned OPERAND_WIDTH = 256,
    parameter int unsigned CHUNK_WIDTH   = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    subtractor_mp_if.slave   bus
);
    localparam int unsigned NCHUNK = OPERAND_WIDTH / CHUNK_WIDTH;
    localparam int unsigned CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CNT_W-1:0] LAST_CHUNK = CNT_W'(NCHUNK - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                   state_q;
    state_t                   state_nxt;
    logic                     accept;
    logic                     step;

    logic [CNT_W-1:0]         cnt_q;
    logic [OPERAND_WIDTH-1:0] a_q;
    logic [OPERAND_WIDTH-1:0] b_q;
    logic                     borrow_q;
    logic [OPERAND_WIDTH-1:0] diff_q;
    logic                     res_borrow_q;
    logic                     res_valid_q;
    logic                     op_ready_q;

    logic [CHUNK_WIDTH:0]     chunk_sum;
    logic [CHUNK_WIDTH-1:0]   chunk_diff;
    logic                     chunk_borrow;

    // Chunk slice: a + ~b + ~borrow, borrow out is the inverted carry out.
    always_comb begin
        chunk_sum    = {1'b0, a_q[CHUNK_WIDTH-1:0]}
                     + {1'b0, ~b_q[CHUNK_WIDTH-1:0]}
                     + {(CHUNK_WIDTH)'(0), ~borrow_q};
        chunk_diff   = chunk_sum[CHUNK_WIDTH-1:0];
        chunk_borrow = ~chunk_sum[CHUNK_WIDTH];
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_nxt;
    end

    // Next-state and datapath control.
    always_comb begin
        state_nxt = state_q;
        accept    = 1'b0;
        step      = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.op_valid && op_ready_q) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (cnt_q == LAST_CHUNK) state_nxt = DONE;
            end
            DONE: begin
                if (bus.res_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operand capture, per-chunk shift/accumulate and registered handshake flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q        <= '0;
            a_q          <= '0;
            b_q          <= '0;
            borrow_q     <= 1'b0;
            diff_q       <= '0;
            res_borrow_q <= 1'b0;
            res_valid_q  <= 1'b0;
            op_ready_q   <= 1'b0;
        end else begin
            op_ready_q  <= (state_nxt == IDLE);
            res_valid_q <= (state_nxt == DONE);
            if (accept) begin
                a_q      <= bus.a;
                b_q      <= bus.b;
                borrow_q <= bus.op_borrow;
                cnt_q    <= '0;
            end else if (step) begin
                a_q      <= a_q >> CHUNK_WIDTH;
                b_q      <= b_q >> CHUNK_WIDTH;
                borrow_q <= chunk_borrow;
                diff_q   <= {chunk_diff, diff_q[OPERAND_WIDTH-1:CHUNK_WIDTH]};
                cnt_q    <= cnt_q + CNT_W'(1);
                if (cnt_q == LAST_CHUNK) res_borrow_q <= chunk_borrow;
            end
        end
    end

`ifdef SUBTRACTOR_MP_OVF_EN
    logic ovf_q;
    logic msb_carry_in;

    // Carry into the MSB recovered from the sum bit; overflow = cin ^ cout.
    always_comb begin
        msb_carry_in = a_q[CHUNK_WIDTH-1] ^ ~b_q[CHUNK_WIDTH-1]
                     ^ chunk_sum[CHUNK_WIDTH-1];
    end

    // Capture overflow on the top chunk only.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (step && (cnt_q == LAST_CHUNK)) begin
            ovf_q <= msb_carry_in ^ chunk_sum[CHUNK_WIDTH];
        end
    end

    assign bus.ovf = ovf_q;
`endif

    assign bus.op_ready   = op_ready_q;
    assign bus.res_valid  = res_valid_q;
    assign bus.diff       = diff_q;
    assign bus.res_borrow = res_borrow_q;

endmodule
